// File: rtl/seq_onehot_encoder.sv
// seq_onehot_encoder
//   Sequential priority encoder. A multi-hot request vector is accepted over a
//   valid/ready handshake. The block then emits the index of every set bit, one
//   index per output beat, in priority order. LSB_FIRST=1 emits the lowest index
//   first and LSB_FIRST=0 emits the highest index first.
//   An all-zero vector produces one beat with out_code=0, out_none=1 and
//   out_last=1.
//
// Parameters
//   N          input vector width (>= 2)
//   W          code width, derived from N (localparam)
//   LSB_FIRST  1: lowest set index first, 0: highest set index first
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   in_data is valid
//   in_ready   block accepts a vector this cycle (registered)
//   in_data    multi-hot request vector
//   out_valid  out_code/out_last/out_none are valid
//   out_ready  consumer takes the current beat
//   out_code   index of the current set bit
//   out_last   final beat of the current vector
//   out_none   latched vector was all-zero
//   out_count  (only with SEQ_ENC_POPCOUNT_EN) number of set bits in the
//              latched vector, held constant for every beat of that vector
//
// Optional feature macro: SEQ_ENC_POPCOUNT_EN
module seq_onehot_encoder #(
  parameter int N = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         out_none
`ifdef SEQ_ENC_POPCOUNT_EN
  ,
  output logic [W:0]   out_count
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]   state_q,     state_d;
  logic [N-1:0] mask_q,      mask_d;
  logic         in_ready_q,  in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_code_q,  out_code_d;
  logic         out_last_q,  out_last_d;
  logic         out_none_q,  out_none_d;

  // Index of the highest-priority set bit. The loop order makes the winning
  // bit the one written last.
  function automatic logic [W-1:0] pick_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) idx = W'(i);
      end
    end
    return idx;
  endfunction

  // Next-state logic. The mask holds the bits that have not been emitted yet.
  // The mask is only empty while in EMIT when the accepted vector was zero.
  // That case produces the single "none" beat.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = EMIT;
          mask_d  = in_data;
        end
      end
      EMIT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d = IDLE;
            mask_d  = '0;
          end else begin
            mask_d = mask_q & ~(N'(1) << out_code_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  // The outputs are computed from the next mask, so every output is a flop.
  // The accepted vector's first beat appears the cycle after acceptance.
  // x & (x-1) == 0 flags a mask with at most one bit set.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == EMIT);
    out_code_d  = out_valid_d ? pick_index(mask_d) : '0;
    out_last_d  = out_valid_d && ((mask_d & (mask_d - N'(1))) == '0);
    out_none_d  = out_valid_d && (mask_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_last_q  <= 1'b0;
      out_none_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_last_q  <= out_last_d;
      out_none_q  <= out_none_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_last  = out_last_q;
  assign out_none  = out_none_q;

`ifdef SEQ_ENC_POPCOUNT_EN
  logic [W:0] count_q, count_d;

  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // The population count is captured at acceptance and held for the whole
  // vector. It is cleared once the last beat has been taken.
  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && in_valid && in_ready_q) begin
      count_d = popcount(in_data);
    end else if (state_d == IDLE) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_seq_onehot_encoder.sv
// tb_seq_onehot_encoder
//   Runs two encoders, LSB-first and MSB-first, from the same stimulus. Their
//   handshakes stay in lock step, so one reference sequence drives both checks.
//   Expected beats come from the set-bit list of each vector.
module tb_seq_onehot_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready0, out_valid0, out_last0, out_none0;
  logic [2:0] out_code0;
  logic       in_ready1, out_valid1, out_last1, out_none1;
  logic [2:0] out_code1;
`ifdef SEQ_ENC_POPCOUNT_EN
  logic [3:0] out_count0, out_count1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_onehot_encoder #(.N(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_code(out_code0), .out_last(out_last0), .out_none(out_none0)
`ifdef SEQ_ENC_POPCOUNT_EN
    , .out_count(out_count0)
`endif
  );

  seq_onehot_encoder #(.N(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_code(out_code1), .out_last(out_last1), .out_none(out_none1)
`ifdef SEQ_ENC_POPCOUNT_EN
    , .out_count(out_count1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid_lsb"}, {31'd0, out_valid0}, 32'd0);
    checkOutput({tag, "_valid_msb"}, {31'd0, out_valid1}, 32'd0);
    checkOutput({tag, "_ready_lsb"}, {31'd0, in_ready0}, 32'd1);
    checkOutput({tag, "_ready_msb"}, {31'd0, in_ready1}, 32'd1);
  endtask

  // Offers one vector and drains all of its beats. stallFirst holds
  // out_ready low for that many cycles before the first beat is taken.
  // randomStall adds 0..2 stall cycles before each later beat.
  task automatic applyStimulus(input logic [7:0] vec, input int stallFirst, input bit randomStall);
    int  idx[$];
    int  n, pop, stalls, guard;
    bit  none;
    idx.delete();
    for (int i = 0; i < 8; i++) if (vec[i]) idx.push_back(i);
    pop  = idx.size();
    none = (pop == 0);
    if (none) idx.push_back(0);
    n = idx.size();

    guard = 0;
    while (!in_ready0 && guard < 10) begin
      tick();
      guard++;
    end
    checkOutput("idle_before_accept", {31'd0, in_ready0}, 32'd1);

    in_valid  = 1'b1;
    in_data   = vec;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    checkOutput("accept_ready_low", {31'd0, in_ready0}, 32'd0);

    for (int k = 0; k < n; k++) begin
      stalls = (k == 0) ? stallFirst : (randomStall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= stalls; s++) begin
        out_ready = (s == stalls);
        checkOutput("beat_valid", {31'd0, out_valid0}, 32'd1);
        checkOutput("beat_valid_msb", {31'd0, out_valid1}, 32'd1);
        checkOutput("beat_in_ready", {31'd0, in_ready0}, 32'd0);
        checkOutput("code_lsb", {29'd0, out_code0}, 32'(idx[k]));
        checkOutput("code_msb", {29'd0, out_code1}, 32'(idx[n-1-k]));
        checkOutput("last_lsb", {31'd0, out_last0}, {31'd0, k == n - 1});
        checkOutput("last_msb", {31'd0, out_last1}, {31'd0, k == n - 1});
        checkOutput("none_lsb", {31'd0, out_none0}, {31'd0, none});
        checkOutput("none_msb", {31'd0, out_none1}, {31'd0, none});
`ifdef SEQ_ENC_POPCOUNT_EN
        checkOutput("count_lsb", {28'd0, out_count0}, 32'(pop));
        checkOutput("count_msb", {28'd0, out_count1}, 32'(pop));
`endif
        tick();
      end
    end
    out_ready = 1'b0;
    checkIdle("after_last");
  endtask

  initial begin
    $display("[TB] start");
    tick();
    tick();
    checkOutput("rst_ready", {31'd0, in_ready0}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid0}, 32'd0);
    checkOutput("rst_code", {29'd0, out_code0}, 32'd0);
    checkOutput("rst_last", {31'd0, out_last0}, 32'd0);
    checkOutput("rst_none", {31'd0, out_none0}, 32'd0);
`ifdef SEQ_ENC_POPCOUNT_EN
    checkOutput("rst_count", {28'd0, out_count0}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("release_ready_low", {31'd0, in_ready0}, 32'd0);
    tick();
    checkIdle("first_edge");

    // Directed vectors: single bit, multi-hot, backpressure, zero, all-ones, two ends.
    applyStimulus(8'b0000_0001, 0, 1'b0);
    applyStimulus(8'b1010_0100, 0, 1'b0);
    applyStimulus(8'b0001_1000, 3, 1'b0);
    applyStimulus(8'h00, 0, 1'b0);
    applyStimulus(8'hFF, 0, 1'b0);
    applyStimulus(8'b1000_0001, 1, 1'b0);

    // Reset in the middle of an all-ones burst.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rb_code_lsb", {29'd0, out_code0}, 32'(k));
      checkOutput("rb_code_msb", {29'd0, out_code1}, 32'(7 - k));
      tick();
    end
    rst = 1'b1;
    #1;
    checkOutput("rb_valid_now", {31'd0, out_valid0}, 32'd0);
    checkOutput("rb_valid_now_msb", {31'd0, out_valid1}, 32'd0);
    checkOutput("rb_ready_now", {31'd0, in_ready0}, 32'd0);
    checkOutput("rb_code_now", {29'd0, out_code0}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rb_release_ready", {31'd0, in_ready0}, 32'd0);
    tick();
    checkIdle("rb_after_release");
    tick();
    tick();
    checkIdle("rb_no_stale");
    out_ready = 1'b0;

    // Random vectors with random backpressure.
    for (int r = 0; r < 24; r++) begin
      applyStimulus(8'($urandom), int'($urandom_range(0, 2)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
